ma_decimator: RTL and testbench

MA_DECIMATOR -- requirements
Module: ma_decimator

---
 rtl/ma_decimator.sv | 111 +++++++++++
 tb/tb_ma_decimator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ma_decimator.sv
// Decimator with a first-word-fall-through output FIFO that follows the moving-average filter.
// Optional MA_DECIMATOR_DROP_CNT_EN adds an 8-bit saturating drop counter on port drop_cnt.
module ma_decimator #(
  parameter int BIT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [BIT_WIDTH-1:0] din,
  input  logic                        din_valid,
  input  logic [2:0]                  dec_sel,
  output logic signed [BIT_WIDTH-1:0] dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        ovf,
  input  logic                        clr_ovf
`ifdef MA_DECIMATOR_DROP_CNT_EN
  ,output logic [7:0]                 drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  function automatic logic [4:0] last_phase(input logic [2:0] sel);
    case (sel)
      3'd0:    return 5'd0;
      3'd1:    return 5'd1;
      3'd2:    return 5'd3;
      3'd3:    return 5'd7;
      3'd4:    return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  logic [2:0]                  dec_sel_p0;
  logic [4:0]                  phase;
  logic                        sel_change;
  logic                        wr_req;
  logic                        wr_en;
  logic                        pop;
  logic                        full;
  logic                        drop;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W:0]              occ;
  logic signed [BIT_WIDTH-1:0] mem [FIFO_DEPTH];

  // A dec_sel change swallows the current edge so the new factor starts from a clean phase.
  assign sel_change = (dec_sel != dec_sel_p0);
  assign wr_req     = din_valid && !sel_change && (phase == last_phase(dec_sel_p0));
  assign dout_valid = (occ != '0);
  assign pop        = dout_valid && dout_ready;
  assign full       = (occ == (PTR_W+1)'(FIFO_DEPTH));
  assign wr_en      = wr_req && (!full || pop);
  assign drop       = wr_req && full && !pop;
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_sel_p0 <= '0;
      phase      <= '0;
    end else begin
      dec_sel_p0 <= dec_sel;
      if (sel_change)
        phase <= '0;
      else if (din_valid)
        phase <= (phase == last_phase(dec_sel_p0)) ? 5'd0 : phase + 5'd1;
    end
  end

  // Decimation / FIFO write boundary
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

`ifdef MA_DECIMATOR_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt <= '0;
    else if (clr_ovf)
      drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ma_decimator.sv
// Scoreboard bench for ma_decimator: expected samples are queued when driven and checked on transfer.
module tb_ma_decimator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] din;
  logic        din_valid;
  logic [2:0]  dec_sel;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        ovf;
  logic        clr_ovf;
`ifdef MA_DECIMATOR_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];

  ma_decimator #(.BIT_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .dec_sel    (dec_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
`ifdef MA_DECIMATOR_DROP_CNT_EN
    ,.drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfers are judged just before the edge that performs them.
  always @(negedge clk) begin
    if (reset_n && dout_valid && dout_ready) begin
      logic [31:0] e;
      e = (sb_q.size() != 0) ? 32'(sb_q.pop_front()) : 32'hDEAD_BEEF;
      check("sb_data", 32'(dout), e);
    end
  end

  task automatic sample(input int v);
    din       = 16'(v);
    din_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; din = '0; din_valid = 1'b0; dec_sel = 3'd0;
    dout_ready = 1'b0; clr_ovf = 1'b0;
    #2;
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

    // N=4 continuous stream, 1-cycle latency
    dec_sel = 3'd2; dout_ready = 1'b1;
    idle(2);
    for (int v = 1; v <= 12; v++) begin
      if (v % 4 == 0) sb_q.push_back(16'(v));
      sample(v);
      if (v % 4 == 0)
        check("n4_latency", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'(v)});
      else if (v % 4 == 1 && v > 1)
        check("n4_gap_valid", 32'(dout_valid), 0);
    end
    idle(3);
    check("n4_drain", 32'(sb_q.size()), 0);

    // N=1 overflow with consumer stalled
    dec_sel = 3'd0; dout_ready = 1'b0;
    idle(2);
    for (int v = 10; v <= 15; v++) begin
      if (v < 14) sb_q.push_back(16'(v));
      sample(v);
      if (v == 13) check("ovf_before_drop", 32'(ovf), 0);
      if (v == 14) check("ovf_5th", 32'(ovf), 1);
    end
    idle(1);
    check("full_occ", 32'(dut.occ), 4);
    check("full_head", 32'(dout), 10);
    check("full_ovf", 32'(ovf), 1);
`ifdef MA_DECIMATOR_DROP_CNT_EN
    check("drop_cnt_2", 32'(drop_cnt), 2);
`endif
    dout_ready = 1'b1;
    idle(5);
    check("ovf_drain", 32'(sb_q.size()), 0);
    check("ovf_sticky", 32'(ovf), 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
`ifdef MA_DECIMATOR_DROP_CNT_EN
    check("drop_cnt_clr", 32'(drop_cnt), 0);
`endif

    // Full FIFO with simultaneous write and pop
    dout_ready = 1'b0;
    for (int v = 20; v <= 23; v++) begin
      sb_q.push_back(16'(v));
      sample(v);
    end
    dout_ready = 1'b1;
    sb_q.push_back(16'd24);
    sample(24);
    check("wp_occ", 32'(dut.occ), 4);
    check("wp_ovf", 32'(ovf), 0);
    check("wp_head", 32'(dout), 21);
    idle(6);
    check("wp_drain", 32'(sb_q.size()), 0);

    // dec_sel switch resets the phase
    dec_sel = 3'd3;
    idle(2);
    for (int v = 30; v <= 34; v++) sample(v);
    dec_sel = 3'd1;
    sample(35);
    check("sw_no_write", 32'(dout_valid), 0);
    for (int v = 36; v <= 40; v++) begin
      if (v == 37 || v == 39) sb_q.push_back(16'(v));
      sample(v);
      if (v == 37) check("sw_2nd", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'd37});
      if (v == 36 || v == 38) check("sw_odd_empty", 32'(dout_valid), 0);
    end
    idle(3);
    check("sw_drain", 32'(sb_q.size()), 0);

    // Asynchronous reset with 3 entries buffered and ovf set
    dec_sel = 3'd0; dout_ready = 1'b0;
    idle(2);
    sb_q.push_back(16'd50);
    for (int v = 50; v <= 54; v++) sample(v);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    check("pre_rst_occ", 32'(dut.occ), 3);
    check("pre_rst_ovf", 32'(ovf), 1);
    #2;
    reset_n = 1'b0;
    dec_sel = 3'd2;
    #1;
    check("arst_dout_valid", 32'(dout_valid), 0);
    check("arst_dout", 32'(dout), 0);
    check("arst_ovf", 32'(ovf), 0);
`ifdef MA_DECIMATOR_DROP_CNT_EN
    check("arst_drop_cnt", 32'(drop_cnt), 0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    check("post_rst_empty", 32'(dout_valid), 0);
    dout_ready = 1'b1;
    for (int v = 60; v <= 67; v++) begin
      if (v == 63 || v == 67) sb_q.push_back(16'(v));
      sample(v);
      if (v < 63) check("post_rst_quiet", 32'(dout_valid), 0);
      if (v == 63) check("post_rst_first", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'd63});
    end
    idle(3);
    check("post_rst_drain", 32'(sb_q.size()), 0);

    // N=32 for dec_sel=7
    dec_sel = 3'd7;
    idle(2);
    for (int v = 1; v <= 64; v++) begin
      if (v % 32 == 0) sb_q.push_back(16'(v));
      sample(v);
    end
    idle(3);
    check("n32_drain", 32'(sb_q.size()), 0);

    // clr_ovf coinciding with a drop keeps ovf set
    dec_sel = 3'd0; dout_ready = 1'b0;
    idle(2);
    for (int v = 70; v <= 73; v++) begin
      sb_q.push_back(16'(v));
      sample(v);
    end
    clr_ovf = 1'b1;
    sample(74);
    clr_ovf = 1'b0;
    check("clr_drop_ovf", 32'(ovf), 1);
`ifdef MA_DECIMATOR_DROP_CNT_EN
    check("clr_drop_cnt", 32'(drop_cnt), 1);
`endif
    dout_ready = 1'b1;
    idle(6);
    check("clr_drop_drain", 32'(sb_q.size()), 0);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("clr_final", 32'(ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
